// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, primary opcodes and the NOP word.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_e;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_J     = 6'h02;
    localparam logic [5:0] OPCODE_JAL   = 6'h03;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_BNE   = 6'h05;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Priority: flush, then stall (hold), then load; otherwise a bubble is inserted.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end else if (stall_i) begin
            valid_q    <= valid_q;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
        end else begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch: PC, req/valid fetch FSM with hold buffer, redirect/flush, IF/ID register.
// Define FETCH_STATS_EN to add the fetch_count / bubble_count statistics ports.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [5:0]  opcode
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    import mips_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  hold_q, hold_d;
    logic         req_q, req_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_instr_in;
    logic [31:0]  ifid_pc4_in;

    assign redirect = jump | branch_taken;
    assign target   = word_align(jump ? jump_target : branch_target);
    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        ifid_load     = 1'b0;
        ifid_flush    = redirect;
        ifid_instr_in = imem_rdata;
        ifid_pc4_in   = pc_plus4;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) pc_d = target;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = target;
                    if (!imem_valid) state_d = S_DRAIN;
                end else if (imem_valid) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // pc_q already points past the buffered word, so it is that word's pc+4.
                if (redirect) begin
                    pc_d    = target;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = hold_q;
                    ifid_pc4_in   = pc_q;
                    hold_d        = '0;
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) pc_d = target;
                if (imem_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // The draining request must keep its original address until the memory answers.
        req_d  = (state_d == S_REQ) || (state_d == S_DRAIN);
        addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock_i    (clock),
        .reset_i    (reset),
        .load_i     (ifid_load),
        .stall_i    (stall),
        .flush_i    (ifid_flush),
        .instr_i    (ifid_instr_in),
        .pc_plus4_i (ifid_pc4_in),
        .valid_o    (if_id_valid),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4)
    );

    assign opcode = if_id_instr[31:26];

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] bubble_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count_q  <= 32'h0000_0000;
            bubble_count_q <= 32'h0000_0000;
        end else begin
            if (ifid_load)    fetch_count_q  <= fetch_count_q + 32'd1;
            if (!if_id_valid) bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a latency-programmable instruction memory model.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  opcode;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory model: answers on the mem_lat-th cycle of a request (1 = zero-wait); data = addr >> 2.
    int wait_cnt;
    int mem_lat = 1;
    bit mem_en  = 1'b1;

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset)                         wait_cnt <= 0;
        else if (imem_req && !imem_valid)  wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    assign imem_valid = imem_req && mem_en && ((wait_cnt + 1) >= mem_lat);
    assign imem_rdata = imem_addr >> 2;

    instruction_fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .opcode         (opcode)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        tick();
        tick();

        // Reset values
        check("rst_req",   imem_req,       32'd0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_valid", if_id_valid,    32'd0);
        check("rst_instr", if_id_instr,    32'h0);
        check("rst_pc4",   if_id_pc_plus4, 32'h0);

        // 1: zero-wait streaming
        reset = 1'b0;
        check("idle_req", imem_req, 32'd0);
        tick();                                       // t1
        check("t1_req",   imem_req,    32'd1);
        check("t1_addr",  imem_addr,   32'h0);
        check("t1_valid", if_id_valid, 32'd0);
        tick();                                       // t2
        check("t2_addr",  imem_addr,      32'h4);
        check("t2_instr", if_id_instr,    32'h0);
        check("t2_valid", if_id_valid,    32'd1);
        check("t2_pc4",   if_id_pc_plus4, 32'h4);
        tick();                                       // t3
        check("t3_addr",  imem_addr,   32'h8);
        check("t3_instr", if_id_instr, 32'h1);
        tick();                                       // t4
        check("t4_addr",  imem_addr,   32'hC);
        check("t4_instr", if_id_instr, 32'h2);

        // 2: three-cycle latency on address 0xC
        mem_lat = 3;
        tick();                                       // t5
        check("lat_addr_a", imem_addr,   32'hC);
        check("lat_bubble", if_id_valid, 32'd0);
        tick();                                       // t6
        check("lat_addr_b", imem_addr,   32'hC);
        check("lat_req_b",  imem_req,    32'd1);
        tick();                                       // t7
        check("lat_instr",  if_id_instr,    32'h3);
        check("lat_valid",  if_id_valid,    32'd1);
        check("lat_pc4",    if_id_pc_plus4, 32'h10);
        check("lat_next",   imem_addr,      32'h10);

        // 3: stall for four edges while the word at 0x10 returns
        stall = 1'b1;
        tick();                                       // t8
        check("stl_instr_a", if_id_instr, 32'h3);
        check("stl_valid_a", if_id_valid, 32'd1);
        check("stl_req_a",   imem_req,    32'd1);
        tick();                                       // t9
        check("stl_instr_b", if_id_instr, 32'h3);
        tick();                                       // t10: word captured into hold buffer
        check("hold_req_a",  imem_req,    32'd0);
        check("hold_instr",  if_id_instr, 32'h3);
        tick();                                       // t11
        check("hold_req_b",  imem_req,    32'd0);
        check("hold_pc4",    if_id_pc_plus4, 32'h10);
        stall = 1'b0;
        tick();                                       // t12
        check("unstl_instr", if_id_instr,    32'h4);
        check("unstl_pc4",   if_id_pc_plus4, 32'h14);
        check("unstl_req",   imem_req,       32'd1);
        check("unstl_addr",  imem_addr,      32'h14);

        // 4: branch to 0x42 (aligned to 0x40) while 0x14 is pending
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        tick();                                       // t13
        branch_taken  = 1'b0;
        check("br_flush_v", if_id_valid, 32'd0);
        check("br_flush_i", if_id_instr, 32'h0);
        check("br_drain_a", imem_addr,   32'h14);
        check("br_drain_r", imem_req,    32'd1);
        tick();                                       // t14
        check("br_drain_b", imem_addr,   32'h14);
        tick();                                       // t15: drain completes, word discarded
        check("br_new_addr", imem_addr,   32'h40);
        check("br_discard",  if_id_valid, 32'd0);
        mem_lat = 1;
        tick();                                       // t16
        check("br_instr", if_id_instr,    32'h10);
        check("br_pc4",   if_id_pc_plus4, 32'h44);

        // 5: jump 0x100 beats branch 0x200, flush overrides stall
        mem_en        = 1'b0;
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        stall         = 1'b1;
        tick();                                       // t17
        jump          = 1'b0;
        branch_taken  = 1'b0;
        stall         = 1'b0;
        mem_en        = 1'b1;
        check("jb_flush_v", if_id_valid, 32'd0);
        check("jb_flush_i", if_id_instr, 32'h0);
        check("jb_drain",   imem_addr,   32'h44);
        tick();                                       // t18
        check("jb_addr",    imem_addr,   32'h100);
        tick();                                       // t19
        check("jb_instr",   if_id_instr,    32'h40);
        check("jb_pc4",     if_id_pc_plus4, 32'h104);

        // Redirect coinciding with a completion, plus pc+4 wrap at the top of memory
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        tick();                                       // t20
        jump        = 1'b0;
        check("wr_addr",   imem_addr,   32'hFFFF_FFFC);
        check("wr_flush",  if_id_valid, 32'd0);
        tick();                                       // t21
        check("wr_instr",  if_id_instr,    32'h3FFF_FFFF);
        check("wr_pc4",    if_id_pc_plus4, 32'h0);
        check("wr_opcode", opcode,         32'h0F);
        check("wr_next",   imem_addr,      32'h0);
        tick();                                       // t22
        check("wr_pc4_b",  if_id_pc_plus4, 32'h4);

        // 6: async reset in the middle of S_DRAIN
        mem_en        = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        tick();                                       // t23
        branch_taken  = 1'b0;
        check("dr_addr", imem_addr, 32'h4);
        check("dr_req",  imem_req,  32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_req",   imem_req,       32'd0);
        check("ar_addr",  imem_addr,      32'h0);
        check("ar_valid", if_id_valid,    32'd0);
        check("ar_instr", if_id_instr,    32'h0);
        check("ar_pc4",   if_id_pc_plus4, 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        mem_en = 1'b1;
        check("ar_idle", imem_req, 32'd0);
        tick();
        check("ar_req_rel",  imem_req,  32'd1);
        check("ar_addr_rel", imem_addr, 32'h0);
        tick();
        check("ar_instr_rel", if_id_instr,    32'h0);
        check("ar_valid_rel", if_id_valid,    32'd1);
        check("ar_pc4_rel",   if_id_pc_plus4, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
